alu_seq: RTL and testbench
==========================

// Module: alu_seq
// PURPOSE
//   Sequential N-bit ALU with a valid/ready handshake on input and output.
//   Single-cycle ops: add/sub, logic and shifts. Multi-cycle iterative ops: multiply and unsigned divide.
//   Result and NZCV flags are registered and held until the consumer takes them.
//   Sits between the register-read stage and writeback in the datapath.
// PARAMETERS
//   N          8   operand/result width, N >= 2
//   MULDIV_EN  1   1: opcodes 10..13 enabled; 0: they behave as reserved
// PORTS
//   clk           in   1   clock, all state on rising edge
//   rst           in   1   synchronous active-high reset
//   in_valid      in   1   operands/opcode valid
//   in_ready      out  1   ALU can accept an operation this cycle
//   a_i           in   N   operand A
//   b_i           in   N   operand B (shift amount for shifts, unsigned)
//   alucontrol    in   4   opcode, sampled at accept
//   out_valid     out  1   result/flags valid
//   out_ready     in   1   consumer takes result this cycle
//   result        out  N   registered result
//   output_flags  out  4   [3]=C [2]=N [1]=V [0]=Z, registered with result
//   busy          out  1   multi-cycle op in progress
// BEHAVIOUR
//   Reset: state=IDLE; in_ready=1; out_valid=0; busy=0; result=0; output_flags=0.
//   Reset mid-operation aborts it; no result is produced.
//   FSM: IDLE -> accept (in_valid&in_ready).
//     If single-cycle op: -> DONE next cycle.
//     If MUL/MULH/DIVU/REMU: -> BUSY.
//   BUSY: N iteration cycles (counter N-1..0), then -> DONE. busy=1 only in BUSY.
//   DONE: out_valid=1. On out_ready: -> IDLE, or accept a new op in the same cycle (back-to-back).
//   in_ready = (state==IDLE) | (state==DONE & out_ready).
//   result/flags change only on leaving IDLE/BUSY into DONE; they stay stable while out_valid & !out_ready.
//   Latency (accept -> out_valid): 1 cycle single-cycle ops; N+1 cycles multi-cycle ops.
//   Opcodes:
//     0 ADD; 1 SUB (a-b); 2 AND; 3 OR; 4 NOT a; 5 XOR
//     6 LSL; 7 ASL (=LSL); 8 LSR; 9 ASR
//     10 MUL (low N bits of unsigned a*b); 11 MULH (high N bits, unsigned)
//     12 DIVU (quotient); 13 REMU (remainder); 14,15 reserved
//   Shifts: amount = unsigned b_i.
//     amount >= N: LSL/ASL/LSR give 0; ASR gives N copies of a[N-1].
//   Flags, all ops: N = result[N-1]; Z = (result==0).
//   ADD: C = carry out; V = signed overflow.
//   SUB: C = 1 when a>=b unsigned (no borrow); V = signed overflow.
//   AND/OR/NOT/XOR: C=0, V=0.
//   Shifts, C: 0 for amount 0; last bit shifted out for amount 1..N; 0 for amount >N.
//     Exception: ASR with amount >N gives C = a[N-1]. V=0 for all shifts.
//   MUL/MULH: C=0; V = (high half of product != 0).
//   DIVU/REMU: restoring division, 1 quotient bit per BUSY cycle; C=0.
//     b=0: quotient = all ones, remainder = a, V=1; otherwise V=0.
//   Reserved (or MULDIV_EN=0 with 10..13): single-cycle; result=0; flags=4'b0001.
//   Operands are captured at accept; input changes during BUSY are ignored.
// TESTING
//   Reset, N=8: assert rst 2 cycles -> out_valid=0, result=0, flags=0, in_ready=1.
//   ADD 8'h7F+8'h01 -> 1 cycle later result=8'h80, flags C0 N1 V1 Z0.
//     SUB 8'h05-8'h05 -> result=0, flags C1 N0 V0 Z1.
//   ASR 8'h90 by 3 -> 8'hF2, C=0; ASR 8'h90 by 9 -> 8'hFF, C=1.
//     LSR 8'h01 by 1 -> 0, C=1, Z=1.
//   MUL 8'h10*8'h20 -> out_valid exactly N+1=9 cycles after accept, result=0, V=1, Z=1.
//     MULH same operands -> 8'h02.
//   DIVU 8'd200/8'd7 -> 8'd28; REMU -> 8'd4.
//     DIVU 8'd9/0 -> 8'hFF, V=1. busy high for 8 cycles.
//   Backpressure: hold out_ready=0 for 5 cycles -> result/flags stable, in_ready=0.
//     Then out_ready=1 with in_valid=1 -> new op accepted the same cycle.
//     Also: rst during BUSY -> IDLE next cycle, no out_valid.

Source files
------------

// File: rtl/alu_seq.sv
// alu_seq: sequential N-bit ALU with valid/ready handshake, registered result and NZCV flags.
module alu_seq #(
  parameter int N = 8,
  parameter bit MULDIV_EN = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  input  logic [3:0]   alucontrol,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] result,
  output logic [3:0]   output_flags,
  output logic         busy
);
  localparam int CW = $clog2(N);
  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;
  state_t r_state, w_next;
  logic [N-1:0] r_hi, r_lo, r_b;
  logic         r_div, r_sel_hi;
  logic [CW-1:0] r_cnt;
  logic w_acc, w_md, w_last;
  logic [N:0] w_add, w_sub, w_lsl, w_lsr, w_sum, w_sh;
  logic signed [N:0] w_asr;
  logic [N-1:0] w_sc_res, w_dif, w_hi_n, w_lo_n, w_md_res;
  logic w_sc_c, w_sc_v, w_ge;
  assign in_ready  = (r_state == S_IDLE) | ((r_state == S_DONE) & out_ready);
  assign out_valid = r_state == S_DONE;
  assign busy      = r_state == S_BUSY;
  assign w_acc     = in_valid & in_ready;
  assign w_md      = MULDIV_EN && alucontrol >= 4'd10 && alucontrol <= 4'd13;
  assign w_last    = (r_state == S_BUSY) && (r_cnt == '0);
  assign w_add = {1'b0, a_i} + {1'b0, b_i};
  assign w_sub = {1'b0, a_i} - {1'b0, b_i};
  // Extra bit beside the operand catches the last bit shifted out as carry.
  assign w_lsl = {1'b0, a_i} << b_i;
  assign w_lsr = {a_i, 1'b0} >> b_i;
  assign w_asr = $signed({a_i, 1'b0}) >>> b_i;
  always_comb begin
    w_sc_res = '0;
    w_sc_c   = 1'b0;
    w_sc_v   = 1'b0;
    case (alucontrol)
      4'd0: begin
        {w_sc_c, w_sc_res} = w_add;
        w_sc_v = (a_i[N-1] == b_i[N-1]) && (w_add[N-1] != a_i[N-1]);
      end
      4'd1: begin
        w_sc_res = w_sub[N-1:0];
        w_sc_c   = ~w_sub[N];
        w_sc_v   = (a_i[N-1] != b_i[N-1]) && (w_sub[N-1] != a_i[N-1]);
      end
      4'd2: w_sc_res = a_i & b_i;
      4'd3: w_sc_res = a_i | b_i;
      4'd4: w_sc_res = ~a_i;
      4'd5: w_sc_res = a_i ^ b_i;
      4'd6, 4'd7: {w_sc_c, w_sc_res} = w_lsl;
      4'd8: {w_sc_res, w_sc_c} = w_lsr;
      4'd9: {w_sc_res, w_sc_c} = w_asr;
      default: ;
    endcase
  end
  // One shift-add multiply step or one restoring-divide step per BUSY cycle.
  assign w_sum    = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : '0);
  assign w_sh     = {r_hi, r_lo[N-1]};
  assign w_ge     = w_sh >= {1'b0, r_b};
  assign w_dif    = w_sh[N-1:0] - r_b;
  assign w_hi_n   = r_div ? (w_ge ? w_dif : w_sh[N-1:0]) : w_sum[N:1];
  assign w_lo_n   = r_div ? {r_lo[N-2:0], w_ge} : {w_sum[0], r_lo[N-1:1]};
  assign w_md_res = r_sel_hi ? w_hi_n : w_lo_n;
  always_comb begin
    w_next = r_state;
    if (w_acc) w_next = w_md ? S_BUSY : S_DONE;
    else if (r_state == S_DONE && out_ready) w_next = S_IDLE;
    else if (w_last) w_next = S_DONE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      result       <= '0;
      output_flags <= '0;
      r_hi         <= '0;
      r_lo         <= '0;
      r_b          <= '0;
      r_div        <= 1'b0;
      r_sel_hi     <= 1'b0;
      r_cnt        <= '0;
    end else begin
      r_state <= w_next;
      if (w_acc) begin
        r_hi     <= '0;
        r_lo     <= a_i;
        r_b      <= b_i;
        r_div    <= alucontrol[2];
        r_sel_hi <= alucontrol[0];
        r_cnt    <= CW'(N - 1);
        if (!w_md) begin
          result       <= w_sc_res;
          output_flags <= {w_sc_c, w_sc_res[N-1], w_sc_v, w_sc_res == '0};
        end
      end else if (r_state == S_BUSY) begin
        r_hi  <= w_hi_n;
        r_lo  <= w_lo_n;
        r_cnt <= r_cnt - 1'b1;
        if (w_last) begin
          result       <= w_md_res;
          output_flags <= {1'b0, w_md_res[N-1], r_div ? (r_b == '0) : (w_hi_n != '0), w_md_res == '0};
        end
      end
    end
  end
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed vectors with hand-computed results for alu_seq (N=8).
module tb_alu_seq;
  logic       clk = 1'b0;
  logic       rst, in_valid, in_ready, out_valid, out_ready, busy;
  logic [7:0] a_i, b_i, result;
  logic [3:0] alucontrol, output_flags;
  int n_tests = 0;
  int n_fail  = 0;
  alu_seq #(.N(8), .MULDIV_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a_i(a_i), .b_i(b_i), .alucontrol(alucontrol),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .output_flags(output_flags), .busy(busy)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  // flags given as {C,N,V,Z}
  task automatic run(input string tag, input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                     input logic [7:0] e_res, input logic [3:0] e_flg, input int e_lat, input int e_busy);
    int lat, nb;
    @(negedge clk);
    in_valid = 1'b1; a_i = a; b_i = b; alucontrol = op;
    chk({tag, ".rdy"}, in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0; a_i = 8'hA5; b_i = 8'h5A; alucontrol = 4'd3;
    lat = 1; nb = 0;
    while (!out_valid && lat < 40) begin
      nb += busy;
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, ".lat"}, lat, e_lat);
    chk({tag, ".busy"}, nb, e_busy);
    chk({tag, ".res"}, result, e_res);
    chk({tag, ".flg"}, output_flags, e_flg);
    @(posedge clk); #1;
  endtask
  initial begin
    int seen;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a_i = '0; b_i = '0; alucontrol = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.ov", out_valid, 0);
    chk("rst.res", result, 0);
    chk("rst.flg", output_flags, 0);
    chk("rst.rdy", in_ready, 1);
    chk("rst.busy", busy, 0);
    rst = 1'b0;
    run("add_ovf",  4'd0,  8'h7F, 8'h01, 8'h80, 4'b0110, 1, 0);
    run("add_c",    4'd0,  8'hFF, 8'h01, 8'h00, 4'b1001, 1, 0);
    run("sub_eq",   4'd1,  8'h05, 8'h05, 8'h00, 4'b1001, 1, 0);
    run("sub_lt",   4'd1,  8'h03, 8'h05, 8'hFE, 4'b0100, 1, 0);
    run("sub_ovf",  4'd1,  8'h80, 8'h01, 8'h7F, 4'b1010, 1, 0);
    run("and",      4'd2,  8'hF0, 8'h3C, 8'h30, 4'b0000, 1, 0);
    run("or",       4'd3,  8'hF0, 8'h0F, 8'hFF, 4'b0100, 1, 0);
    run("not",      4'd4,  8'h55, 8'h00, 8'hAA, 4'b0100, 1, 0);
    run("xor",      4'd5,  8'hFF, 8'hFF, 8'h00, 4'b0001, 1, 0);
    run("lsl1",     4'd6,  8'h81, 8'd1,  8'h02, 4'b1000, 1, 0);
    run("asl8",     4'd7,  8'h81, 8'd8,  8'h00, 4'b1001, 1, 0);
    run("lsl9",     4'd6,  8'h81, 8'd9,  8'h00, 4'b0001, 1, 0);
    run("lsr1",     4'd8,  8'h01, 8'd1,  8'h00, 4'b1001, 1, 0);
    run("lsr0",     4'd8,  8'h80, 8'd0,  8'h80, 4'b0100, 1, 0);
    run("asr3",     4'd9,  8'h90, 8'd3,  8'hF2, 4'b0100, 1, 0);
    run("asr8",     4'd9,  8'h80, 8'd8,  8'hFF, 4'b1100, 1, 0);
    run("asr9",     4'd9,  8'h90, 8'd9,  8'hFF, 4'b1100, 1, 0);
    run("rsvd",     4'd14, 8'h12, 8'h34, 8'h00, 4'b0001, 1, 0);
    run("mul",      4'd10, 8'h10, 8'h20, 8'h00, 4'b0011, 9, 8);
    run("mulh",     4'd11, 8'h10, 8'h20, 8'h02, 4'b0010, 9, 8);
    run("mul_ff",   4'd10, 8'hFF, 8'hFF, 8'h01, 4'b0010, 9, 8);
    run("mulh_ff",  4'd11, 8'hFF, 8'hFF, 8'hFE, 4'b0110, 9, 8);
    run("divu",     4'd12, 8'd200, 8'd7, 8'd28, 4'b0000, 9, 8);
    run("remu",     4'd13, 8'd200, 8'd7, 8'd4,  4'b0000, 9, 8);
    run("divu0",    4'd12, 8'd9,  8'd0,  8'hFF, 4'b0110, 9, 8);
    run("remu0",    4'd13, 8'd9,  8'd0,  8'd9,  4'b0010, 9, 8);
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b1; a_i = 8'h01; b_i = 8'h02; alucontrol = 4'd0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("bp.ov", out_valid, 1);
    repeat (5) begin
      @(posedge clk); #1;
      chk("bp.hold_ov", out_valid, 1);
      chk("bp.hold_res", result, 8'h03);
      chk("bp.hold_flg", output_flags, 4'b0000);
      chk("bp.hold_rdy", in_ready, 0);
    end
    @(negedge clk);
    out_ready = 1'b1; in_valid = 1'b1; a_i = 8'h10; b_i = 8'h01; alucontrol = 4'd1;
    #1 chk("b2b.rdy", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("b2b.ov", out_valid, 1);
    chk("b2b.res", result, 8'h0F);
    chk("b2b.flg", output_flags, 4'b1000);
    @(posedge clk); #1;
    chk("b2b.idle", out_valid, 0);
    @(negedge clk);
    in_valid = 1'b1; a_i = 8'h10; b_i = 8'h20; alucontrol = 4'd10;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("abort.busy_pre", busy, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort.ov", out_valid, 0);
    chk("abort.busy", busy, 0);
    chk("abort.rdy", in_ready, 1);
    chk("abort.res", result, 0);
    seen = 0;
    repeat (12) begin
      @(posedge clk); #1;
      seen += out_valid;
    end
    chk("abort.no_ov", seen, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
